// File: rtl/tohost_monitor.sv
// tohost_monitor: snoops riscv-tests tohost stores and latches the verdict.
// Optional watchdog enabled by defining TOHOST_MONITOR_TIMEOUT_EN.
module tohost_monitor #(
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    parameter int unsigned TIMEOUT     = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_be,
    input  logic [31:0] mem_wdata,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic        done_pulse,
    output logic [30:0] test_num,
    output logic [31:0] cycles
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    // A watchdog shorter than two cycles cannot be expressed.
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("tohost_monitor: TIMEOUT must be at least 2");
    end

`ifdef TOHOST_MONITOR_TIMEOUT_EN
    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT - 1);
    localparam logic [31:0] WDOG_CNT  = 32'(TIMEOUT);
`endif

    state_t      state_q, state_d;
    logic [30:0] test_num_q, test_num_d;
    logic [31:0] cycles_q, cycles_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic        timeout_q, timeout_d;
    logic        done_q, done_d;
    logic        done_pulse_q, done_pulse_d;

    logic        hit;
    logic        is_pass;
    logic        is_fail;

    // Qualify the store: full-word write to exactly the tohost address.
    always_comb begin
        hit     = mem_we && (mem_addr == TOHOST_ADDR) && (mem_be == 4'hF);
        is_pass = hit && (mem_wdata == 32'd1);
        is_fail = hit && mem_wdata[0] && (mem_wdata != 32'd1);
    end

    // Next state, cycle counter and failing test number.
    always_comb begin
        state_d    = state_q;
        test_num_d = test_num_q;
        cycles_d   = cycles_q;
        if (state_q == ST_RUN) begin
            if (cycles_q != 32'hFFFF_FFFF) begin
                cycles_d = cycles_q + 32'd1;
            end
            if (is_pass) begin
                state_d = ST_PASS;
            end else if (is_fail) begin
                state_d    = ST_FAIL;
                test_num_d = mem_wdata[31:1];
            end
`ifdef TOHOST_MONITOR_TIMEOUT_EN
            else if (cycles_q == WDOG_LAST) begin
                state_d  = ST_TIMEOUT;
                cycles_d = WDOG_CNT;
            end
`endif
        end
    end

    // Registered flag outputs decoded from the upcoming state.
    always_comb begin
        pass_d       = (state_d == ST_PASS);
        fail_d       = (state_d == ST_FAIL);
`ifdef TOHOST_MONITOR_TIMEOUT_EN
        timeout_d    = (state_d == ST_TIMEOUT);
`else
        timeout_d    = 1'b0;
`endif
        done_d       = (state_d != ST_RUN);
        done_pulse_d = (state_q == ST_RUN) && (state_d != ST_RUN);
    end

    // State and holding registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            test_num_q   <= '0;
            cycles_q     <= '0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            test_num_q   <= test_num_d;
            cycles_q     <= cycles_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
            done_q       <= done_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    assign done       = done_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign timeout    = timeout_q;
    assign done_pulse = done_pulse_q;
    assign test_num   = test_num_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// tb_tohost_monitor: directed scoreboard bench for tohost_monitor.
// Watchdog expectations follow TOHOST_MONITOR_TIMEOUT_EN.
module tb_tohost_monitor;

    localparam logic [31:0] ADDR = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        done, pass, fail, timeout, done_pulse;
    logic [30:0] test_num;
    logic [31:0] cycles;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       tag;
        logic [4:0]  flags;
        logic [30:0] tn;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];

    tohost_monitor #(.TOHOST_ADDR(ADDR), .TIMEOUT(50)) dut (
        .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .done(done),
        .pass(pass), .fail(fail), .timeout(timeout),
        .done_pulse(done_pulse), .test_num(test_num), .cycles(cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // flags = {done_pulse, done, pass, fail, timeout}
    task automatic expect_out(string tag, logic [4:0] f,
                              logic [30:0] tn, logic [31:0] cyc);
        exp_t e;
        e.tag = tag; e.flags = f; e.tn = tn; e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".flags"},
                64'({done_pulse, done, pass, fail, timeout}), 64'(e.flags));
            chk({e.tag, ".test_num"}, 64'(test_num), 64'(e.tn));
            chk({e.tag, ".cycles"}, 64'(cycles), 64'(e.cyc));
        end
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(logic we, logic [31:0] a, logic [3:0] be,
                         logic [31:0] d);
        mem_we = we; mem_addr = a; mem_be = be; mem_wdata = d;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 4'h0, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        // A valid pass write while in reset must be ignored.
        drive(1'b1, ADDR, 4'hF, 32'd1);
        tick();
        expect_out("reset", 5'b00000, 31'd0, 32'd0);
        tick();
        rst = 1'b0;
        idle();

        // Pass after 20 idle cycles.
        ticks(19);
        expect_out("idle20", 5'b00000, 31'd0, 32'd20);
        tick();
        drive(1'b1, ADDR, 4'hF, 32'd1);
        expect_out("pass", 5'b11100, 31'd0, 32'd21);
        tick();
        idle();
        expect_out("pass_pulse_end", 5'b01100, 31'd0, 32'd21);
        tick();
        ticks(4);
        drive(1'b1, ADDR, 4'hF, 32'd7);
        expect_out("pass_hold", 5'b01100, 31'd0, 32'd21);
        tick();
        idle();

        // Fail decode, later pass write ignored.
        do_reset();
        ticks(5);
        drive(1'b1, ADDR, 4'hF, 32'h0000_0007);
        expect_out("fail", 5'b11010, 31'd3, 32'd6);
        tick();
        drive(1'b1, ADDR, 4'hF, 32'd1);
        expect_out("fail_hold", 5'b01010, 31'd3, 32'd6);
        tick();
        idle();

        // Reset after a fail verdict, then pass from a fresh count.
        rst = 1'b1;
        expect_out("mid_reset", 5'b00000, 31'd0, 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b1, ADDR, 4'hF, 32'd1);
        expect_out("pass_after_reset", 5'b11100, 31'd0, 32'd1);
        tick();
        idle();

        // Ignored writes, then a valid pass.
        do_reset();
        drive(1'b1, ADDR, 4'h1, 32'd1);
        expect_out("ign_be", 5'b00000, 31'd0, 32'd1);
        tick();
        drive(1'b1, ADDR + 32'd4, 4'hF, 32'd1);
        expect_out("ign_addr", 5'b00000, 31'd0, 32'd2);
        tick();
        drive(1'b1, ADDR, 4'hF, 32'd2);
        expect_out("ign_even", 5'b00000, 31'd0, 32'd3);
        tick();
        drive(1'b1, ADDR, 4'hF, 32'd0);
        expect_out("ign_zero", 5'b00000, 31'd0, 32'd4);
        tick();
        drive(1'b0, ADDR, 4'hF, 32'd1);
        expect_out("ign_we", 5'b00000, 31'd0, 32'd5);
        tick();
        drive(1'b1, ADDR, 4'hF, 32'd1);
        expect_out("pass_after_ign", 5'b11100, 31'd0, 32'd6);
        tick();
        idle();

        // Largest failing test number.
        do_reset();
        drive(1'b1, ADDR, 4'hF, 32'hFFFF_FFFF);
        expect_out("fail_max", 5'b11010, 31'h7FFF_FFFF, 32'd1);
        tick();
        idle();

        // Watchdog with no writes.
        do_reset();
        ticks(48);
        expect_out("wd_49", 5'b00000, 31'd0, 32'd49);
        tick();
`ifdef TOHOST_MONITOR_TIMEOUT_EN
        expect_out("wd_fire", 5'b11001, 31'd0, 32'd50);
        tick();
        drive(1'b1, ADDR, 4'hF, 32'd1);
        expect_out("wd_hold", 5'b01001, 31'd0, 32'd50);
        tick();
        idle();
`else
        expect_out("wd_off_50", 5'b00000, 31'd0, 32'd50);
        tick();
        ticks(29);
        expect_out("wd_off_80", 5'b00000, 31'd0, 32'd80);
        tick();
`endif

        // Pass write in the watchdog cycle wins.
        do_reset();
        ticks(49);
        drive(1'b1, ADDR, 4'hF, 32'd1);
        expect_out("wd_race_pass", 5'b11100, 31'd0, 32'd50);
        tick();
        idle();
        expect_out("wd_race_hold", 5'b01100, 31'd0, 32'd50);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
